// File: rtl/_piso_tx_pkg.sv
// Shared definitions for the parallel-in/serial-out transmitter.
// Holds the state encoding and the default word/counter widths, so the
// transmitter and any matching receiver bench agree on them.
package _piso_tx_pkg;

  // Default data word width and bit-counter width (2**CNT_W >= WIDTH).
  localparam int PISO_WIDTH = 8;
  localparam int PISO_CNT_W = 3;

  // Transmitter states. 2'b11 is never entered on purpose; it is decoded
  // so that a corrupted state register recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SHIFT   = 2'b01,
    ST_DONE    = 2'b10,
    ST_ILLEGAL = 2'b11
  } piso_state_e;

endpackage : _piso_tx_pkg

// File: rtl/_piso_tx_shift_reg.sv
// WIDTH-bit shift register used as the transmit data path.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset, clears q
//   ld       parallel load of d (has priority over sh)
//   sh       shift right by one, zero fill at the MSB
//   d        parallel load data
//   q        register contents; q[0] is the bit on the line
module _shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ld,
  input  logic             sh,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;

  // Shift register storage: load beats shift, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_r <= {WIDTH{1'b0}};
    end else if (ld) begin
      q_r <= d;
    end else if (sh) begin
      q_r <= {1'b0, q_r[WIDTH-1:1]};
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule : _shift_reg

// File: rtl/_piso_tx.sv
// Parallel-in/serial-out transmitter. A WIDTH-bit word is accepted in one
// cycle (load while ready) and shifted out LSB-first, one bit per tick.
// A single-cycle done strobe follows the last bit's tick.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   load     request to transmit d_in; accepted only while ready=1
//   d_in     parallel word, sampled on the accepting edge only
//   tick     bit-advance enable; the current bit is held until a tick
//   s_out    serial data (IDLE_LVL when not shifting)
//   ready    1 in IDLE
//   busy     1 in SHIFT or DONE (~ready)
//   done     1-cycle strobe after the last bit's tick
module _piso_tx
  import _piso_tx_pkg::*;
#(
  parameter int   WIDTH    = PISO_WIDTH,
  parameter int   CNT_W    = PISO_CNT_W,
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  input  logic             tick,
  output logic             s_out,
  output logic             ready,
  output logic             busy,
  output logic             done
);

  piso_state_e      state_r;
  piso_state_e      state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             ld_s;
  logic             sh_s;
  logic [WIDTH-1:0] shreg_s;

  _shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .ld      (ld_s),
    .sh      (sh_s),
    .d       (d_in),
    .q       (shreg_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Remaining-bit counter: WIDTH-1 on accept, counts down on ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  // Next-state, counter and shift-register control decode.
  // On the final tick (cnt==0) the register is left alone: the counter is
  // tested before it would be decremented, so it never wraps.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    ld_s        = 1'b0;
    sh_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (load) begin
          ld_s        = 1'b1;
          cnt_nxt_s   = CNT_W'(WIDTH - 1);
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_nxt_s = ST_DONE;
          end else begin
            sh_s      = 1'b1;
            cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Outputs are pure decodes of the state and register so bit0 shows up in
  // the very cycle after the accepting edge.
  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    s_out = IDLE_LVL;
    if (state_r == ST_IDLE) begin
      ready = 1'b1;
    end else begin
      ready = 1'b0;
    end
    if (state_r == ST_DONE) begin
      done = 1'b1;
    end else begin
      done = 1'b0;
    end
    if (state_r == ST_SHIFT) begin
      s_out = shreg_s[0];
    end else begin
      s_out = IDLE_LVL;
    end
  end

  assign busy = ~ready;

endmodule : _piso_tx

// File: tb/tb__piso_tx.sv
module tb__piso_tx;

  localparam int W = 8;

  logic         clk;
  logic         reset_n;
  logic         load;
  logic [W-1:0] d_in;
  logic         tick;
  logic         s_out;
  logic         ready;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  // Reference model: a frame is a word plus the index of the bit on the line.
  bit           m_active;
  bit           m_done;
  int           m_k;
  logic [W-1:0] m_word;
  int           m_dones;
  int           dut_dones;

  _piso_tx #(.WIDTH(8), .CNT_W(3), .IDLE_LVL(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .d_in    (d_in),
    .tick    (tick),
    .s_out   (s_out),
    .ready   (ready),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_done   = 1'b0;
    m_k      = 0;
    m_word   = '0;
  endtask

  task automatic check_outputs();
    logic e_ready;
    logic e_sout;
    e_ready = !m_active && !m_done;
    e_sout  = m_active ? m_word[m_k] : 1'b1;
    chk("s_out", 32'(s_out), 32'(e_sout));
    chk("ready", 32'(ready), 32'(e_ready));
    chk("busy",  32'(busy),  32'(!e_ready));
    chk("done",  32'(done),  32'(m_done));
  endtask

  // One clock: called at a negedge; checks, drives, advances model, returns at next negedge.
  task automatic cycle(input logic l, input logic [W-1:0] d, input logic t);
    load = l;
    d_in = d;
    tick = t;
    check_outputs();
    if (done === 1'b1) dut_dones++;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_active) begin
      if (t) begin
        if (m_k == W - 1) begin
          m_active = 1'b0;
          m_done   = 1'b1;
          m_dones++;
        end else begin
          m_k++;
        end
      end
    end else if (l) begin
      m_active = 1'b1;
      m_k      = 0;
      m_word   = d;
    end
    @(negedge clk);
  endtask

  initial begin
    // 1: reset held with load=1, d_in=FF: no accept.
    reset_n = 1'b0; load = 1'b1; d_in = 8'hFF; tick = 1'b0;
    m_dones = 0; dut_dones = 0;
    model_reset();
    #1;
    chk("rst_s_out", 32'(s_out), 32'd1);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hFF, 1'b1);
    reset_n = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);

    // 2: basic frame A5, tick constantly high.
    cycle(1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 11; i++) cycle(1'b0, 8'h00, 1'b1);

    // 3: sparse tick, one every 4th cycle.
    cycle(1'b1, 8'h3C, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00, (i % 4) == 3);

    // 4: load attempt mid-frame is ignored.
    cycle(1'b1, 8'h81, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h7E, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("single_done_81", 32'(dut_dones), 32'(m_dones));

    // 5: back-to-back with load held; second accept after done.
    cycle(1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 22; i++) cycle(1'b1, 8'h80, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);

    // 6: mid-frame asynchronous reset after 5 ticks of F0.
    cycle(1'b1, 8'hF0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_s_out", 32'(s_out), 32'd1);
    chk("arst_ready", 32'(ready), 32'd1);
    chk("arst_busy",  32'(busy),  32'd0);
    chk("arst_done",  32'(done),  32'd0);
    model_reset();
    @(negedge clk);
    cycle(1'b0, 8'h00, 1'b1);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h55, 1'b1);
    for (int i = 0; i < 11; i++) cycle(1'b0, 8'h00, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 30; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("done_count", 32'(dut_dones), 32'(m_dones));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb__piso_tx
